// File: rtl/writeback_stage_if.sv
// writeback_stage_if: execute -> writeback retire handshake.
//   ex_valid     execute presents an instruction
//   ex_ready     writeback stage can accept this cycle
//   ex_dest      destination register index
//   ex_result    ALU result
//   ex_is_load   instruction is a load (data comes from memory)
//   ex_reg_write instruction writes a register
// Modports: master = execute side, slave = writeback side.
interface writeback_stage_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [DATA_W-1:0]     ex_result;
    logic                  ex_is_load;
    logic                  ex_reg_write;

    modport master (
        output ex_valid, ex_dest, ex_result, ex_is_load, ex_reg_write,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_dest, ex_result, ex_is_load, ex_reg_write,
        output ex_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage feeding the 16x32 register bank.
// Retires one instruction per cycle from execute, selecting the ALU result or
// returned load data, and issues exactly one single-cycle register write per
// committing instruction. Loads wait at most LOAD_TIMEOUT cycles for data.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   ex                    execute handshake (writeback_stage_if.slave)
//   mem_rdata_valid/rdata load data return
//   err_clr               clears load_timeout_err
//   destination           register bank write index
//   ldr_mux_in            register bank write data
//   reg_write             register bank write enable (one cycle per commit)
//   busy                  high while waiting for load data
//   load_timeout_err      sticky: a load was abandoned
// Optional: define WB_BYPASS_EN to add byp_valid/byp_dest/byp_data, which
// mirror the write in progress for operand forwarding.
module writeback_stage #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_ADDR_W   = 4,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    writeback_stage_if.slave      ex,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  err_clr,
    output logic [REG_ADDR_W-1:0] destination,
    output logic [DATA_W-1:0]     ldr_mux_in,
    output logic                  reg_write,
    output logic                  busy,
    output logic                  load_timeout_err
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_dest,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLoad = 2'd1,
        StCommit   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign ex.ex_ready = (state_q != StWaitLoad);
    assign accept      = ex.ex_valid && ex.ex_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        data_d  = data_q;
        // A timeout below overrides the clear when both land on one edge.
        err_d   = err_q && !err_clr;
        case (state_q)
            StIdle, StCommit: begin
                state_d = StIdle;
                if (accept && ex.ex_reg_write) begin
                    dest_d = ex.ex_dest;
                    if (ex.ex_is_load) begin
                        cnt_d   = '0;
                        state_d = StWaitLoad;
                    end else begin
                        data_d  = ex.ex_result;
                        state_d = StCommit;
                    end
                end
            end
            StWaitLoad: begin
                if (mem_rdata_valid) begin
                    // Data wins even on the last allowed cycle.
                    data_d  = mem_rdata;
                    state_d = StCommit;
                end else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dest_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from flops so the bank never sees a glitch.
    assign destination      = dest_q;
    assign ldr_mux_in       = data_q;
    assign reg_write        = (state_q == StCommit);
    assign busy             = (state_q == StWaitLoad);
    assign load_timeout_err = err_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = reg_write;
    assign byp_dest  = dest_q;
    assign byp_data  = data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_ADDR_W   = 4;
    localparam int unsigned LOAD_TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  mem_rdata_valid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  err_clr;
    logic [REG_ADDR_W-1:0] destination;
    logic [DATA_W-1:0]     ldr_mux_in;
    logic                  reg_write;
    logic                  busy;
    logic                  load_timeout_err;
`ifdef WB_BYPASS_EN
    logic                  byp_valid;
    logic [REG_ADDR_W-1:0] byp_dest;
    logic [DATA_W-1:0]     byp_data;
`endif

    int checks = 0;
    int errors = 0;

    writeback_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) wb_if ();

    writeback_stage #(
        .DATA_W       (DATA_W),
        .REG_ADDR_W   (REG_ADDR_W),
        .LOAD_TIMEOUT (LOAD_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ex               (wb_if.slave),
        .mem_rdata_valid  (mem_rdata_valid),
        .mem_rdata        (mem_rdata),
        .err_clr          (err_clr),
        .destination      (destination),
        .ldr_mux_in       (ldr_mux_in),
        .reg_write        (reg_write),
        .busy             (busy),
        .load_timeout_err (load_timeout_err)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid        (byp_valid),
        .byp_dest         (byp_dest),
        .byp_data         (byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks whether a load is outstanding, how long it has
    // waited, whether a write is being presented, and the bank-side values.
    bit                  m_waiting;
    int                  m_waited;
    bit                  m_commit;
    logic [REG_ADDR_W-1:0] m_dest;
    logic [DATA_W-1:0]   m_data;
    bit                  m_err;

    logic [39:0] obs, exp_vec;
    assign obs     = {reg_write, busy, wb_if.ex_ready, load_timeout_err, destination, ldr_mux_in};
    assign exp_vec = {m_commit, m_waiting, !m_waiting, m_err, m_dest, m_data};

    task automatic drive(input bit v, input logic [3:0] d, input logic [31:0] r,
                         input bit ld, input bit rw);
        wb_if.ex_valid     = v;
        wb_if.ex_dest      = d;
        wb_if.ex_result    = r;
        wb_if.ex_is_load   = ld;
        wb_if.ex_reg_write = rw;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        mem_rdata_valid = 1'b0;
        err_clr         = 1'b0;
    endtask

    // Advance one clock edge, update the model from the inputs sampled at that
    // edge, and return 1 time unit later so outputs are settled.
    task automatic step();
        bit next_err;
        @(posedge clk);
        if (!reset_n) begin
            m_waiting = 0; m_waited = 0; m_commit = 0;
            m_dest = '0; m_data = '0; m_err = 0;
        end else begin
            next_err = m_err && !err_clr;
            m_commit = 0;
            if (m_waiting) begin
                if (mem_rdata_valid) begin
                    m_data = mem_rdata; m_waiting = 0; m_commit = 1;
                end else begin
                    m_waited++;
                    if (m_waited >= LOAD_TIMEOUT) begin
                        m_waiting = 0; next_err = 1;
                    end
                end
            end else if (wb_if.ex_valid && wb_if.ex_reg_write) begin
                m_dest = wb_if.ex_dest;
                if (wb_if.ex_is_load) begin
                    m_waiting = 1; m_waited = 0;
                end else begin
                    m_data = wb_if.ex_result; m_commit = 1;
                end
            end
            m_err = next_err;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 4'hA, 32'h1234_5678, 1'b0, 1'b1);
        mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; err_clr = 1'b0;
        step(); step();
        checks++;
        if (obs !== 40'h20_0000_0000) begin
            $display("FAIL reset: got %h want %h", obs, 40'h20_0000_0000); errors++;
        end
        checks++;
        if (obs !== exp_vec) begin
            $display("FAIL reset_model: got %h want %h", obs, exp_vec); errors++;
        end
        idle();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_alu_single();
        drive(1'b1, 4'd3, 32'd100, 1'b0, 1'b1);
        step();
        checks++;
        if (reg_write !== 1'b1 || destination !== 4'd3 || ldr_mux_in !== 32'd100) begin
            $display("FAIL alu_single: got rw=%b d=%0d data=%0d want rw=1 d=3 data=100",
                     reg_write, destination, ldr_mux_in);
            errors++;
        end
        idle();
        step();
        checks++;
        if (obs !== exp_vec || reg_write !== 1'b0) begin
            $display("FAIL alu_single_after: got %h want %h", obs, exp_vec); errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  dests [3];
        logic [31:0] vals [3];
        dests = '{4'd1, 4'd2, 4'd7};
        vals  = '{32'd5, 32'd6, 32'd7};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wb_if.ex_ready !== 1'b1) begin
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, wb_if.ex_ready); errors++;
            end
            drive(1'b1, dests[i], vals[i], 1'b0, 1'b1);
            step();
            checks++;
            if (obs !== exp_vec || reg_write !== 1'b1 || destination !== dests[i]
                || ldr_mux_in !== vals[i]) begin
                $display("FAIL b2b[%0d]: got %h want %h", i, obs, exp_vec); errors++;
            end
        end
        idle();
        step();
    endtask

    task automatic test_load();
        drive(1'b1, 4'd5, 32'h5555_5555, 1'b1, 1'b1);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_vec || busy !== 1'b1 || wb_if.ex_ready !== 1'b0) begin
                $display("FAIL load_wait[%0d]: got %h want %h", i, obs, exp_vec); errors++;
            end
            // Offer an instruction that must be refused while waiting.
            drive(1'b1, 4'd9, 32'h9, 1'b0, 1'b1);
            if (i == 3) begin
                mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        checks++;
        if (reg_write !== 1'b1 || destination !== 4'd5 || ldr_mux_in !== 32'hDEAD_BEEF
            || obs !== exp_vec) begin
            $display("FAIL load_commit: got %h want %h", obs, exp_vec); errors++;
        end
        idle();
        step();
    endtask

    task automatic test_timeout();
        drive(1'b1, 4'd4, 32'h0, 1'b1, 1'b1);
        step();
        idle();
        for (int i = 0; i < int'(LOAD_TIMEOUT); i++) begin
            checks++;
            if (obs !== exp_vec || reg_write !== 1'b0) begin
                $display("FAIL timeout_wait[%0d]: got %h want %h", i, obs, exp_vec); errors++;
            end
            step();
        end
        checks++;
        if (load_timeout_err !== 1'b1 || busy !== 1'b0 || reg_write !== 1'b0) begin
            $display("FAIL timeout_err: got err=%b busy=%b rw=%b want 1 0 0",
                     load_timeout_err, busy, reg_write);
            errors++;
        end
        mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        checks++;
        if (obs !== exp_vec || reg_write !== 1'b0) begin
            $display("FAIL late_data: got %h want %h", obs, exp_vec); errors++;
        end
        // Second timeout with err_clr on the very same edge: set wins.
        idle();
        drive(1'b1, 4'd6, 32'h0, 1'b1, 1'b1);
        step();
        idle();
        for (int i = 0; i < int'(LOAD_TIMEOUT); i++) begin
            err_clr = (i == int'(LOAD_TIMEOUT) - 1);
            step();
        end
        checks++;
        if (load_timeout_err !== 1'b1 || obs !== exp_vec) begin
            $display("FAIL clr_vs_set: got %h want %h", obs, exp_vec); errors++;
        end
        err_clr = 1'b1;
        step();
        checks++;
        if (load_timeout_err !== 1'b0 || obs !== exp_vec) begin
            $display("FAIL err_clr: got %h want %h", obs, exp_vec); errors++;
        end
        // Data arriving on the final allowed cycle commits without error.
        idle();
        drive(1'b1, 4'd8, 32'h0, 1'b1, 1'b1);
        step();
        idle();
        for (int i = 0; i < int'(LOAD_TIMEOUT); i++) begin
            if (i == int'(LOAD_TIMEOUT) - 1) begin
                mem_rdata_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
            end
            step();
        end
        checks++;
        if (reg_write !== 1'b1 || load_timeout_err !== 1'b0 || ldr_mux_in !== 32'hCAFE_F00D
            || obs !== exp_vec) begin
            $display("FAIL final_cycle_data: got %h want %h", obs, exp_vec); errors++;
        end
        idle();
        step();
    endtask

    task automatic test_no_write();
        logic [3:0]  d0;
        logic [31:0] v0;
        d0 = destination;
        v0 = ldr_mux_in;
        drive(1'b1, 4'd12, 32'h7777_7777, 1'b0, 1'b0);
        step();
        checks++;
        if (reg_write !== 1'b0 || destination !== d0 || ldr_mux_in !== v0
            || obs !== exp_vec) begin
            $display("FAIL no_write: got %h want %h", obs, exp_vec); errors++;
        end
        idle();
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 4'd11, 32'h0, 1'b1, 1'b1);
        step();
        idle();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        mem_rdata_valid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        checks++;
        if (obs !== 40'h20_0000_0000 || obs !== exp_vec) begin
            $display("FAIL reset_in_wait: got %h want %h", obs, exp_vec); errors++;
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(99) >= 2);
            drive($urandom_range(99) < 70, 4'($urandom), $urandom,
                  $urandom_range(99) < 30, $urandom_range(99) < 85);
            mem_rdata_valid = ($urandom_range(99) < 15);
            mem_rdata       = $urandom;
            err_clr         = ($urandom_range(99) < 5);
            step();
            checks++;
            if (obs !== exp_vec) begin
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec); errors++;
            end
        end
        reset_n = 1'b1;
        idle();
        step();
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(99) < 70, 4'($urandom), $urandom,
                  $urandom_range(99) < 30, 1'b1);
            mem_rdata_valid = ($urandom_range(99) < 40);
            mem_rdata       = $urandom;
            step();
            checks++;
            if ({byp_valid, byp_dest, byp_data} !== {m_commit, m_dest, m_data}) begin
                $display("FAIL bypass[%0d]: got %b/%h/%h want %b/%h/%h", i, byp_valid,
                         byp_dest, byp_data, m_commit, m_dest, m_data);
                errors++;
            end
        end
        idle();
        step();
    endtask
`endif

    initial begin
        idle();
        mem_rdata = '0;
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_load();
        test_timeout();
        test_no_write();
        test_reset_in_wait();
        test_random();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
